// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer and its FIFO.
package fetch_pkg;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t RUN   = 1'b0;
  localparam fetch_state_t FAULT = 1'b1;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

  localparam logic [15:0] INSTR_BYTES = 16'd4;

  // The last byte of the word is checked in 17 bits so 16'hFFFC cannot wrap into range.
  function automatic logic addr_legal(input logic [15:0] a, input int unsigned mem_size);
    logic [16:0] last_byte;
    last_byte = {1'b0, a} + 17'd3;
    return (a[1:0] == 2'b00) && (32'(last_byte) < mem_size);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of {pc, instr} entries between fetch and decode; flush empties it at once.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; count gates visibility so stale words are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and fetch front end: drives the ROM address and queues fetched words toward decode.
// Optional FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          MEM_SIZE = 1024,
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic        fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  fetch_state_t            state;
  logic [15:0]             pc;
  logic                    pc_legal;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;
  fetch_entry_t            head;

  assign pc_legal = addr_legal(pc, MEM_SIZE);
  assign pop      = out_valid && out_ready;
  // A full FIFO may still fetch when decode drains the head in the same cycle.
  assign push     = (state == RUN) && !redirect_valid && pc_legal && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      state <= addr_legal(redirect_pc, MEM_SIZE) ? RUN : FAULT;
    end else if (state == RUN) begin
      if (!pc_legal)  state <= FAULT;
      else if (push)  pc    <= pc + INSTR_BYTES;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ('{pc: pc, instr: imem_instr}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign imem_addr = pc;
  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign fault     = (state == FAULT);

`ifdef FETCH_PERF_EN
  logic stall;
  assign stall = (state == RUN) && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (push && perf_fetched != '1)         perf_fetched <= perf_fetched + 32'd1;
      if (stall && perf_stall != '1)          perf_stall   <= perf_stall + 32'd1;
      if (redirect_valid && perf_flush != '1) perf_flush   <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a queue-based model of the fetch rules.
module tb_fetch_sequencer;

  localparam int          MEM_SIZE = 1024;
  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rom [MEM_SIZE/4];

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 16'(MEM_SIZE)) ? rom[imem_addr[9:2]] : 16'hDEAD;

  fetch_sequencer #(.MEM_SIZE(MEM_SIZE), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int pc;
    int instr;
  } ent_t;

  ent_t q[$];
  int   m_pc;
  bit   m_fault;
  bit   m_init = 1'b0;
  int   m_fetched, m_stall, m_flush;

  function automatic bit m_legal(input int a);
    return (a % 4 == 0) && (a + 3 < MEM_SIZE);
  endfunction

  always @(posedge clk) begin
    bit do_pop;
    if (reset) begin
      q.delete();
      m_pc      = int'(RESET_PC);
      m_fault   = 1'b0;
      m_init    = 1'b1;
      m_fetched = 0;
      m_stall   = 0;
      m_flush   = 0;
    end else if (m_init) begin
      do_pop = (q.size() != 0) && out_ready;
      if (!m_fault && q.size() == DEPTH && !do_pop) m_stall++;
      if (redirect_valid) begin
        q.delete();
        m_pc    = int'(redirect_pc);
        m_fault = !m_legal(m_pc);
        m_flush++;
      end else begin
        if (do_pop) void'(q.pop_front());
        if (!m_fault) begin
          if (!m_legal(m_pc)) m_fault = 1'b1;
          else if (q.size() < DEPTH) begin
            q.push_back('{pc: m_pc, instr: int'(rom[m_pc / 4])});
            m_pc += 4;
            m_fetched++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("pc", 32'(out_pc), 32'(q[0].pc));
        check("instr", 32'(out_instr), 32'(q[0].instr));
      end
      check("fault", 32'(fault), 32'(m_fault));
      check("imem_addr", 32'(imem_addr), 32'(m_pc));
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, 32'(m_fetched));
      check("perf_stall", perf_stall, 32'(m_stall));
      check("perf_flush", perf_flush, 32'(m_flush));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'(RESET_PC));
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    for (int k = 0; k < MEM_SIZE / 4; k++) rom[k] = 16'($urandom);

    // Full sequential sweep to the last word, then fault at 1024.
    do_reset();
    for (int i = 0; i < MEM_SIZE / 4; i++) begin
      tick();
      check("seq_pc", 32'(out_pc), 32'(4 * i));
      check("seq_valid", 32'(out_valid), 32'd1);
    end
    tick();
    check("end_fault", 32'(fault), 32'd1);
    check("end_valid", 32'(out_valid), 32'd0);
    check("end_addr", 32'(imem_addr), 32'd1024);
    repeat (2) tick();
    check("end_addr_hold", 32'(imem_addr), 32'd1024);
    redirect(16'h0000);
    check("redir0_fault", 32'(fault), 32'd0);
    check("redir0_valid", 32'(out_valid), 32'd0);
    tick();
    check("redir0_pc", 32'(out_pc), 32'd0);

    // Back-pressure: FIFO fills with pc 0,4 and the PC parks at 8.
    do_reset();
    out_ready = 1'b0;
    repeat (5) tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_head", 32'(out_pc), 32'd0);
    check("bp_addr", 32'(imem_addr), 32'd8);
`ifdef FETCH_PERF_EN
    check("bp_perf_stall", perf_stall, 32'd3);
    check("bp_perf_fetched", perf_fetched, 32'd2);
`endif
    out_ready = 1'b1;
    tick();
    check("bp_rel_4", 32'(out_pc), 32'd4);
    tick();
    check("bp_rel_8", 32'(out_pc), 32'd8);

    // Redirect while full: one empty cycle, then the new stream only.
    out_ready = 1'b0;
    repeat (3) tick();
    redirect(16'h0040);
    check("flush_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick();
    check("flush_pc40", 32'(out_pc), 32'h40);
    tick();
    check("flush_pc44", 32'(out_pc), 32'h44);

    // Misaligned redirect faults without fetching; reset mid-stream recovers.
    redirect(16'h0006);
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_valid", 32'(out_valid), 32'd0);
    check("mis_addr", 32'(imem_addr), 32'h6);
    tick();
    check("mis_nopush", 32'(out_valid), 32'd0);
    redirect(16'h0100);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midrst_fault", 32'(fault), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'(RESET_PC));
    reset = 1'b0;

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      out_ready      = ($urandom_range(0, 99) < 70);
      reset          = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 4))
        0: redirect_pc = 16'($urandom_range(0, MEM_SIZE / 4 - 1) * 4);
        1: redirect_pc = 16'(MEM_SIZE - 4 * $urandom_range(1, 6));
        2: redirect_pc = 16'($urandom_range(0, MEM_SIZE / 4 - 1) * 4 + $urandom_range(1, 3));
        3: redirect_pc = 16'(MEM_SIZE + 4 * $urandom_range(0, 100));
        default: redirect_pc = 16'hFFFC;
      endcase
      tick();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
